ysyx_22041211_ifu_prefetch: RTL

Parametrised instruction-fetch unit with a prefetch queue. It replaces the combinational same-cycle instruction read of the single-cycle core with a decoupled fetch path. It issues in-order read requests to instruction memory over a valid/ready request/response pair and buffers up to DEPTH instructions with their PCs and fault flags. It delivers them to the decoder over a valid/ready handshake and flushes cleanly on branch/jump redirects.

---
 rtl/ysyx_22041211_ifu_prefetch_if.sv | 38 +++
 rtl/ysyx_22041211_ifu_prefetch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_ifu_prefetch_if.sv
// Fetch-unit bus bundle: memory request/response channels, redirect input and
// the decoder-facing instruction channel, seen from the fetch unit (master).
interface ysyx_22041211_ifu_prefetch_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) ();
    logic                req_valid_o;
    logic                req_ready_i;
    logic [ADDR_LEN-1:0] req_addr_o;

    logic                rsp_valid_i;
    logic                rsp_ready_o;
    logic [DATA_LEN-1:0] rsp_data_i;
    logic                rsp_err_i;

    logic                redirect_i;
    logic [ADDR_LEN-1:0] redirect_pc_i;

    logic                inst_valid_o;
    logic                inst_ready_i;
    logic [DATA_LEN-1:0] inst_o;
    logic [ADDR_LEN-1:0] inst_pc_o;
    logic                inst_err_o;

    modport master (
        output req_valid_o, req_addr_o, rsp_ready_o,
        output inst_valid_o, inst_o, inst_pc_o, inst_err_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i,
        input  redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, rsp_ready_o,
        input  inst_valid_o, inst_o, inst_pc_o, inst_err_o,
        output req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i,
        output redirect_i, redirect_pc_i, inst_ready_i
    );
endinterface

// File: rtl/ysyx_22041211_ifu_prefetch.sv
// Decoupled instruction fetch: in-order memory requests feed a DEPTH-slot queue
// of {pc, data, err}; redirects flush the queue and drop late responses.
module ysyx_22041211_ifu_prefetch #(
    parameter int                  ADDR_LEN = 32,
    parameter int                  DATA_LEN = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic clk,
    input  logic rst,
    ysyx_22041211_ifu_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW:0] ptr_t;

    localparam ptr_t             ONE     = ptr_t'(1);
    localparam ptr_t             ZERO    = ptr_t'(0);
    localparam logic [PW+1:0]    DEPTH_W = (PW+2)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end

    // Architectural state
    logic [ADDR_LEN-1:0] fetch_pc_reg, fetch_pc_next;
    ptr_t                alloc_ptr_reg, alloc_ptr_next;
    ptr_t                fill_ptr_reg, fill_ptr_next;
    ptr_t                rd_ptr_reg, rd_ptr_next;
    ptr_t                drop_cnt_reg, drop_cnt_next;

    logic [ADDR_LEN-1:0] pc_mem   [DEPTH];
    logic [DATA_LEN-1:0] data_mem [DEPTH];
    logic                err_mem  [DEPTH];

    // Derived occupancy and handshakes
    ptr_t          in_use;
    ptr_t          pending;
    ptr_t          rd_post;
    logic [PW+1:0] credit_used;
    logic          has_credit;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_accept;
    logic          drop_active;
    logic          rsp_orphan;
    logic          rsp_consumed;
    logic          rsp_fill;
    logic          inst_valid;
    logic          pop;

    logic [PW-1:0] alloc_idx;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] rd_idx;

    assign alloc_idx = alloc_ptr_reg[PW-1:0];
    assign fill_idx  = fill_ptr_reg[PW-1:0];
    assign rd_idx    = rd_ptr_reg[PW-1:0];

    assign in_use      = alloc_ptr_reg - rd_ptr_reg;
    assign pending     = alloc_ptr_reg - fill_ptr_reg;
    // Stale responses still in flight hold credit just like live slots.
    assign credit_used = {1'b0, in_use} + {1'b0, drop_cnt_reg};
    assign has_credit  = credit_used < DEPTH_W;

    assign req_valid = rst & ~bus.redirect_i & has_credit;
    assign req_fire  = req_valid & bus.req_ready_i;

    assign rsp_accept   = rst & bus.rsp_valid_i;
    assign drop_active  = drop_cnt_reg != ZERO;
    assign rsp_orphan   = rsp_accept & ~drop_active & (pending == ZERO);
    assign rsp_consumed = rsp_accept & ~rsp_orphan;
    assign rsp_fill     = rsp_accept & ~bus.redirect_i & ~drop_active & ~rsp_orphan;

    assign inst_valid = rst & (rd_ptr_reg != fill_ptr_reg);
    assign pop        = inst_valid & bus.inst_ready_i;
    assign rd_post    = rd_ptr_reg + (pop ? ONE : ZERO);

    always_comb begin
        fetch_pc_next  = fetch_pc_reg;
        alloc_ptr_next = alloc_ptr_reg;
        fill_ptr_next  = fill_ptr_reg;
        rd_ptr_next    = rd_post;
        drop_cnt_next  = drop_cnt_reg;

        if (bus.redirect_i) begin
            // Everything behind the (possibly popped) head is flushed; every
            // request still awaiting memory becomes a response to drop.
            alloc_ptr_next = rd_post;
            fill_ptr_next  = rd_post;
            drop_cnt_next  = drop_cnt_reg + pending - (rsp_consumed ? ONE : ZERO);
            fetch_pc_next  = {bus.redirect_pc_i[ADDR_LEN-1:2], 2'b00};
        end else begin
            if (req_fire) begin
                alloc_ptr_next = alloc_ptr_reg + ONE;
                fetch_pc_next  = fetch_pc_reg + ADDR_LEN'(4);
            end
            if (rsp_accept && drop_active) begin
                drop_cnt_next = drop_cnt_reg - ONE;
            end
            if (rsp_fill) begin
                fill_ptr_next = fill_ptr_reg + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_reg  <= RESET_PC;
            alloc_ptr_reg <= ZERO;
            fill_ptr_reg  <= ZERO;
            rd_ptr_reg    <= ZERO;
            drop_cnt_reg  <= ZERO;
        end else begin
            fetch_pc_reg  <= fetch_pc_next;
            alloc_ptr_reg <= alloc_ptr_next;
            fill_ptr_reg  <= fill_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    // PC is captured at issue time, data/err when the matching response lands.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[alloc_idx] <= fetch_pc_reg;
        end
        if (rsp_fill) begin
            data_mem[fill_idx] <= bus.rsp_data_i;
            err_mem[fill_idx]  <= bus.rsp_err_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!rsp_orphan)
                else $error("ifu_prefetch: response received with no request outstanding");
        end
    end

    assign bus.req_valid_o  = req_valid;
    assign bus.req_addr_o   = fetch_pc_reg;
    assign bus.rsp_ready_o  = rst;
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = data_mem[rd_idx];
    assign bus.inst_pc_o    = pc_mem[rd_idx];
    assign bus.inst_err_o   = err_mem[rd_idx];

endmodule
